mips_multicycle_control: RTL
============================

# mips_multicycle_control

Main control FSM for the multi-cycle MIPS datapath. It sequences the shared ALU, memory port, instruction register and register file across fetch, decode, execute, memory and write-back cycles. It drives the 4-bit ALU operation code consumed by the ALU control decoder, which maps it, together with the funct field, to the 3-bit ALU control bits. It stalls on a single-bit memory ready handshake.

## Interface
- No parameters; all encodings are constants in the shared package.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register; valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, pc_write_beq, pc_write_bne  out  1  unconditional PC load / load if zero / load if not zero
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read, mem_write, ir_write  out  1  memory strobes; instruction register load
- reg_dst  out  1  write-register source: 0 = rt, 1 = rd
- mem_to_reg, reg_write  out  1  write-back data source (1 = MDR); register file write enable
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B input: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_op  out  4  ALU operation code: 0000 add (lw/sw), 0001 sub (beq/bne), 0010 R-type, 0011 addi, 0100 andi, 0101 ori, 0110 slti/sltiu
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported

## Operation
- Supported opcodes:
  - R 000000, j 000010
  - beq 000100, bne 000101
  - addi 001000, slti 001010, sltiu 001011, andi 001100, ori 001101
  - lw 100011, sw 101011
- Outputs are decoded from the state (Moore), except pc_write and ir_write in FETCH, which are qualified by mem_ready.
- Every output not listed for a state is 0.
- States and required outputs:
  - IDLE: all outputs 0. Always moves to FETCH.
  - FETCH: mem_read=1, alu_src_b=01, alu_op=0000. pc_write=ir_write=mem_ready. Holds while mem_ready=0, then moves to DECODE.
  - DECODE: alu_src_b=11, alu_op=0000 (branch target into ALUOut). Next state by opcode:
    - lw/sw -> MEMADDR
    - R -> EXEC_R
    - beq/bne -> BRANCH
    - j -> JUMP
    - immediate ops -> EXEC_I
    - anything else -> FETCH, with illegal_op=1
  - MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=0000. Moves to MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: mem_read=1, iord=1. Holds until mem_ready, then moves to MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Moves to FETCH.
  - MEMWRITE: mem_write=1, iord=1. Holds until mem_ready, then moves to FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=0010. Moves to RWB.
  - RWB: reg_write=1, reg_dst=1. Moves to FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op per opcode (sltiu uses 0110). Moves to IWB.
  - IWB: reg_write=1, reg_dst=0. Moves to FETCH.
  - BRANCH: alu_src_a=1, alu_op=0001, pc_source=01, pc_write_beq=1 for beq or pc_write_bne=1 for bne. Moves to FETCH.
  - JUMP: pc_write=1, pc_source=10. Moves to FETCH.
- The opcode is sampled in DECODE. The opcode is also used in MEMADDR, EXEC_I and BRANCH; the IR is stable because ir_write=0 outside FETCH.

## Timing
- Reset asserted at any time, including mid-access: state becomes IDLE immediately and all outputs go to 0 without waiting for a clock. An in-flight mem_write is dropped.
- First FETCH occurs on the first clock edge after reset deasserts.
- Cycles per instruction with mem_ready tied high:
  - R, immediate ops, sw: 4
  - lw: 5
  - beq/bne, j: 3
  - illegal opcode: 2
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Strobes stay asserted throughout a stall.
- pc_write and ir_write must never assert during a FETCH stall cycle (otherwise a double PC increment).
- mem_ready outside memory states is ignored.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode constants
  - the alu_op encodings listed above
  - the ALUSrcB and PCSource encodings
  - the state enum (4-bit)
- The ALU control decoder imports the same alu_op constants.
- One natural sub-module: mips_opcode_class, a combinational decoder from opcode to {is_mem, is_load, is_r, is_imm, is_beq, is_bne, is_j, alu_op_imm}. DECODE, MEMADDR, EXEC_I and BRANCH all use it.

## Test plan
- Reset, then lw (100011) with mem_ready=1 -> states IDLE, FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, FETCH; reg_write=mem_to_reg=1 only in MEMWB.
- add (R-type) with mem_ready low for 3 FETCH cycles -> mem_read held for 4 cycles; pc_write/ir_write exactly 1 pulse; alu_op=0010 in EXEC_R; reg_dst=1 in RWB.
- bne then beq -> BRANCH asserts pc_write_bne only, then pc_write_beq only, with alu_op=0001 and pc_source=01; 3 cycles each.
- Sweep addi/andi/ori/slti/sltiu -> EXEC_I alu_op = 0011/0100/0101/0110/0110; IWB reg_dst=0.
- opcode 111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH; no reg_write or mem_write.
- sw with mem_ready=0, reset asserted mid-MEMWRITE -> mem_write drops to 0 in the same cycle; FETCH after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM and the ALU control decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [3:0] AluOpAdd   = 4'b0000;
  localparam logic [3:0] AluOpSub   = 4'b0001;
  localparam logic [3:0] AluOpRType = 4'b0010;
  localparam logic [3:0] AluOpAddi  = 4'b0011;
  localparam logic [3:0] AluOpAndi  = 4'b0100;
  localparam logic [3:0] AluOpOri   = 4'b0101;
  localparam logic [3:0] AluOpSlt   = 4'b0110;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StMemAddr, StMemRead, StMemWb, StMemWrite,
    StExecR, StRwb, StExecI, StIwb, StBranch, StJump
  } ctrl_state_e;

  typedef struct packed {
    logic       is_mem;
    logic       is_load;
    logic       is_r;
    logic       is_imm;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic [3:0] alu_op_imm;
  } op_class_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control/status bundle between the main control FSM (master) and the datapath (slave).
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_beq;
  logic       pc_write_bne;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [3:0] alu_op;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_op,
           illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_op,
           illegal_op
  );
endinterface

// File: rtl/mips_opcode_class.sv
// Combinational opcode classifier; unsupported opcodes decode to all-zero.
module mips_opcode_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output op_class_t  class_o
);

  always_comb begin
    class_o = '0;
    case (opcode_i)
      OpLw:    begin class_o.is_mem = 1'b1; class_o.is_load = 1'b1; end
      OpSw:    class_o.is_mem = 1'b1;
      OpRType: class_o.is_r   = 1'b1;
      OpBeq:   class_o.is_beq = 1'b1;
      OpBne:   class_o.is_bne = 1'b1;
      OpJ:     class_o.is_j   = 1'b1;
      OpAddi:  begin class_o.is_imm = 1'b1; class_o.alu_op_imm = AluOpAddi; end
      OpAndi:  begin class_o.is_imm = 1'b1; class_o.alu_op_imm = AluOpAndi; end
      OpOri:   begin class_o.is_imm = 1'b1; class_o.alu_op_imm = AluOpOri;  end
      OpSlti, OpSltiu: begin class_o.is_imm = 1'b1; class_o.alu_op_imm = AluOpSlt; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: Moore outputs, except the FETCH
// pc_write/ir_write which are qualified by mem_ready so a stalled fetch never double-increments.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_i,
  mips_multicycle_control_if.master         ctrl_io
);

  ctrl_state_e state_q, state_d;
  op_class_t   cls;

  mips_opcode_class u_opcode_class (
    .opcode_i (ctrl_io.opcode),
    .class_o  (cls)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     state_d = StFetch;
      StFetch:    if (ctrl_io.mem_ready) state_d = StDecode;
      StDecode: begin
        if (cls.is_mem)                   state_d = StMemAddr;
        else if (cls.is_r)                state_d = StExecR;
        else if (cls.is_beq || cls.is_bne) state_d = StBranch;
        else if (cls.is_j)                state_d = StJump;
        else if (cls.is_imm)              state_d = StExecI;
        else                              state_d = StFetch;
      end
      StMemAddr:  state_d = cls.is_load ? StMemRead : StMemWrite;
      StMemRead:  if (ctrl_io.mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (ctrl_io.mem_ready) state_d = StFetch;
      StExecR:    state_d = StRwb;
      StRwb:      state_d = StFetch;
      StExecI:    state_d = StIwb;
      StIwb:      state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    ctrl_io.pc_write     = 1'b0;
    ctrl_io.pc_write_beq = 1'b0;
    ctrl_io.pc_write_bne = 1'b0;
    ctrl_io.iord         = 1'b0;
    ctrl_io.mem_read     = 1'b0;
    ctrl_io.mem_write    = 1'b0;
    ctrl_io.ir_write     = 1'b0;
    ctrl_io.reg_dst      = 1'b0;
    ctrl_io.mem_to_reg   = 1'b0;
    ctrl_io.reg_write    = 1'b0;
    ctrl_io.alu_src_a    = 1'b0;
    ctrl_io.alu_src_b    = SrcBReg;
    ctrl_io.pc_source    = PcSrcAlu;
    ctrl_io.alu_op       = AluOpAdd;
    ctrl_io.illegal_op   = 1'b0;
    case (state_q)
      StFetch: begin
        ctrl_io.mem_read  = 1'b1;
        ctrl_io.alu_src_b = SrcBFour;
        ctrl_io.pc_write  = ctrl_io.mem_ready;
        ctrl_io.ir_write  = ctrl_io.mem_ready;
      end
      StDecode: begin
        ctrl_io.alu_src_b  = SrcBImmSh;
        ctrl_io.illegal_op = ~(cls.is_mem | cls.is_r | cls.is_beq | cls.is_bne |
                               cls.is_j | cls.is_imm);
      end
      StMemAddr: begin
        ctrl_io.alu_src_a = 1'b1;
        ctrl_io.alu_src_b = SrcBImm;
      end
      StMemRead: begin
        ctrl_io.mem_read = 1'b1;
        ctrl_io.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl_io.reg_write  = 1'b1;
        ctrl_io.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        ctrl_io.mem_write = 1'b1;
        ctrl_io.iord      = 1'b1;
      end
      StExecR: begin
        ctrl_io.alu_src_a = 1'b1;
        ctrl_io.alu_op    = AluOpRType;
      end
      StRwb: begin
        ctrl_io.reg_write = 1'b1;
        ctrl_io.reg_dst   = 1'b1;
      end
      StExecI: begin
        ctrl_io.alu_src_a = 1'b1;
        ctrl_io.alu_src_b = SrcBImm;
        ctrl_io.alu_op    = cls.alu_op_imm;
      end
      StIwb:   ctrl_io.reg_write = 1'b1;
      StBranch: begin
        ctrl_io.alu_src_a    = 1'b1;
        ctrl_io.alu_op       = AluOpSub;
        ctrl_io.pc_source    = PcSrcAluOut;
        ctrl_io.pc_write_beq = cls.is_beq;
        ctrl_io.pc_write_bne = cls.is_bne;
      end
      StJump: begin
        ctrl_io.pc_write  = 1'b1;
        ctrl_io.pc_source = PcSrcJump;
      end
      default: ;
    endcase
  end

endmodule
